// File: rtl/sys_tile_scheduler_if.sv
// Host/controller-facing bundle for the GEMM tile scheduler.
// Slave is the scheduler, master is whoever drives the job and the finish.
interface sys_tile_scheduler_if #(
  parameter int INTEGER_BIT = 8
);
  logic                   start;
  logic [INTEGER_BIT-1:0] dim_m;
  logic [INTEGER_BIT-1:0] dim_k;
  logic [INTEGER_BIT-1:0] dim_n;
  logic                   ws_os_in;
  logic                   sys_finish;
  logic                   sys_enable;
  logic                   ws_os;
  logic [INTEGER_BIT-1:0] tile_m;
  logic [INTEGER_BIT-1:0] tile_k;
  logic [INTEGER_BIT-1:0] tile_n;
  logic [INTEGER_BIT-1:0] m_off;
  logic [INTEGER_BIT-1:0] k_off;
  logic [INTEGER_BIT-1:0] n_off;
  logic                   acc_first;
  logic                   acc_last;
  logic [15:0]            tile_count;
  logic                   busy;
  logic                   done;

  modport slave (
    input  start, dim_m, dim_k, dim_n,
    input  ws_os_in, sys_finish,
    output sys_enable, ws_os,
    output tile_m, tile_k, tile_n,
    output m_off, k_off, n_off,
    output acc_first, acc_last,
    output tile_count, busy, done
  );

  modport master (
    output start, dim_m, dim_k, dim_n,
    output ws_os_in, sys_finish,
    input  sys_enable, ws_os,
    input  tile_m, tile_k, tile_n,
    input  m_off, k_off, n_off,
    input  acc_first, acc_last,
    input  tile_count, busy, done
  );
endinterface

// File: rtl/sys_tile_scheduler.sv
// Walks one M x K x N GEMM through the systolic controller tile by tile.
// Loop order: k innermost, then m, then n, so k partial sums stay contiguous.
module sys_tile_scheduler #(
  parameter int SYS_ARR_SIZE = 8,
  parameter int M_TILE       = 16,
  parameter int INTEGER_BIT  = 8
) (
  input logic clk,
  input logic reset,
  sys_tile_scheduler_if.slave bus
);
  localparam int W = INTEGER_BIT;
  localparam logic [W-1:0] SA = W'(SYS_ARR_SIZE);
  localparam logic [W-1:0] MT = W'(M_TILE);

  typedef enum logic [2:0] {
    IDLE, LOAD, RUN, RELEASE, NEXT, DONE
  } state_e;

  state_e       state_q;
  logic [W-1:0] dm_q, dk_q, dn_q;
  logic [W-1:0] m_off_q, k_off_q, n_off_q;
  logic [W-1:0] tm_q, tk_q, tn_q;
  logic         en_q, ws_q;
  logic         first_q, last_q;
  logic         busy_q, done_q;
  logic [15:0]  cnt_q;

  logic [W-1:0] rem_m, rem_k, rem_n;
  logic [W:0]   m_d, k_d, n_d;
  logic         adv_m, adv_k, adv_n;
  logic         zero_dim;

  assign rem_m = dm_q - m_off_q;
  assign rem_k = dk_q - k_off_q;
  assign rem_n = dn_q - n_off_q;

  // off + step < dim is the same test as remainder > step, without wrap
  assign m_d   = {1'b0, m_off_q} + {1'b0, MT};
  assign k_d   = {1'b0, k_off_q} + {1'b0, SA};
  assign n_d   = {1'b0, n_off_q} + {1'b0, SA};
  assign adv_m = m_d < {1'b0, dm_q};
  assign adv_k = k_d < {1'b0, dk_q};
  assign adv_n = n_d < {1'b0, dn_q};

  assign zero_dim = (bus.dim_m == '0) ||
                    (bus.dim_k == '0) ||
                    (bus.dim_n == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dm_q    <= '0;
      dk_q    <= '0;
      dn_q    <= '0;
      m_off_q <= '0;
      k_off_q <= '0;
      n_off_q <= '0;
      tm_q    <= '0;
      tk_q    <= '0;
      tn_q    <= '0;
      en_q    <= 1'b0;
      ws_q    <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            dm_q    <= bus.dim_m;
            dk_q    <= bus.dim_k;
            dn_q    <= bus.dim_n;
            ws_q    <= bus.ws_os_in;
            m_off_q <= '0;
            k_off_q <= '0;
            n_off_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            if (zero_dim) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          tm_q    <= (rem_m > MT) ? MT : rem_m;
          tk_q    <= (rem_k > SA) ? SA : rem_k;
          tn_q    <= (rem_n > SA) ? SA : rem_n;
          first_q <= (k_off_q == '0);
          last_q  <= !adv_k;
          en_q    <= 1'b1;
          state_q <= RUN;
        end
        RUN: begin
          if (bus.sys_finish) begin
            en_q    <= 1'b0;
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          if (cnt_q != 16'hFFFF)
            cnt_q <= cnt_q + 16'd1;
          state_q <= NEXT;
        end
        NEXT: begin
          if (adv_k) begin
            k_off_q <= k_d[W-1:0];
            state_q <= LOAD;
          end else begin
            k_off_q <= '0;
            if (adv_m) begin
              m_off_q <= m_d[W-1:0];
              state_q <= LOAD;
            end else begin
              m_off_q <= '0;
              if (adv_n) begin
                n_off_q <= n_d[W-1:0];
                state_q <= LOAD;
              end else begin
                done_q  <= 1'b1;
                state_q <= DONE;
              end
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sys_enable = en_q;
  assign bus.ws_os      = ws_q;
  assign bus.tile_m     = tm_q;
  assign bus.tile_k     = tk_q;
  assign bus.tile_n     = tn_q;
  assign bus.m_off      = m_off_q;
  assign bus.k_off      = k_off_q;
  assign bus.n_off      = n_off_q;
  assign bus.acc_first  = first_q;
  assign bus.acc_last   = last_q;
  assign bus.tile_count = cnt_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_sys_tile_scheduler.sv
// Bench for sys_tile_scheduler: a loop-nest tile model plus a
// behavioural systolic controller with random finish latency.
module tb_sys_tile_scheduler;
  localparam int SA = 8;
  localparam int MT = 16;
  localparam int W  = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sys_tile_scheduler_if #(.INTEGER_BIT(W)) bus ();

  sys_tile_scheduler #(
    .SYS_ARR_SIZE(SA),
    .M_TILE(MT),
    .INTEGER_BIT(W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    int m, k, n;
    int mo, ko, no;
    bit f, l;
  } tile_t;

  int    checks = 0;
  int    failures = 0;
  tile_t exp_q[$];
  tile_t last_seen;

  function automatic int min2(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void build(int M, int K, int N);
    tile_t t;
    exp_q.delete();
    if (M == 0 || K == 0 || N == 0) return;
    for (int no = 0; no < N; no += SA)
      for (int mo = 0; mo < M; mo += MT)
        for (int ko = 0; ko < K; ko += SA) begin
          t.m  = min2(MT, M - mo);
          t.k  = min2(SA, K - ko);
          t.n  = min2(SA, N - no);
          t.mo = mo;
          t.ko = ko;
          t.no = no;
          t.f  = (ko == 0);
          t.l  = (ko + SA >= K);
          exp_q.push_back(t);
        end
  endfunction

  // lat_fix >= 0 fixes finish latency; rst_tile > 0 resets mid-run there
  task automatic run_job(input int M, input int K, input int N,
                         input bit ws, input int lat_fix,
                         input bit noise, input int rst_tile);
    int    ntiles, idx, low, en_cnt, lat;
    bit    prev_en, ended;
    tile_t t, last_t;
    build(M, K, N);
    ntiles  = exp_q.size();
    if (ntiles > 0) last_t = exp_q[ntiles-1];
    idx     = 0;
    low     = 0;
    en_cnt  = 0;
    lat     = 0;
    prev_en = 1'b0;
    ended   = 1'b0;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dim_m    = W'(M);
    bus.dim_k    = W'(K);
    bus.dim_n    = W'(N);
    bus.ws_os_in = ws;
    for (int cyc = 1; cyc <= 60000 && !ended; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
          failures++;
          $display("FAIL busy_after_start got=%b want=1", bus.busy);
        end
      end
      if (cyc == 2) begin
        checks++;
        if (bus.sys_enable !== (ntiles > 0)) begin
          failures++;
          $display("FAIL enable_at_start_plus2 got=%b want=%b",
                   bus.sys_enable, ntiles > 0);
        end
      end
      if (bus.sys_enable === 1'b1) begin
        if (!prev_en) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL extra_tile idx=%0d got=tile want=none", idx);
          end else begin
            t = exp_q.pop_front();
          end
          if (idx > 0) begin
            checks++;
            if (low != 3) begin
              failures++;
              $display("FAIL enable_gap idx=%0d got=%0d want=3", idx, low);
            end
          end
          checks++;
          if (bus.tile_count !== 16'(idx) || bus.ws_os !== ws) begin
            failures++;
            $display("FAIL count_ws idx=%0d got=%0d/%b want=%0d/%b",
                     idx, bus.tile_count, bus.ws_os, idx, ws);
          end
          last_seen.m  = int'(bus.tile_m);
          last_seen.k  = int'(bus.tile_k);
          last_seen.n  = int'(bus.tile_n);
          last_seen.mo = int'(bus.m_off);
          last_seen.ko = int'(bus.k_off);
          last_seen.no = int'(bus.n_off);
          last_seen.f  = bus.acc_first;
          last_seen.l  = bus.acc_last;
          idx++;
          en_cnt = 0;
          lat = (lat_fix >= 0) ? lat_fix : $urandom_range(0, 3);
          if (rst_tile == idx) begin
            reset = 1'b1;
            bus.sys_finish = 1'b0;
            bus.start = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.sys_enable !== 1'b0 || bus.busy !== 1'b0 ||
                bus.done !== 1'b0 || bus.tile_count !== 16'd0 ||
                bus.tile_m !== '0 || bus.tile_k !== '0 ||
                bus.tile_n !== '0 || bus.m_off !== '0 ||
                bus.k_off !== '0 || bus.n_off !== '0 ||
                bus.acc_first !== 1'b0 || bus.acc_last !== 1'b0 ||
                bus.ws_os !== 1'b0) begin
              failures++;
              $display("FAIL reset_mid_run got en=%b busy=%b done=%b cnt=%0d want all 0",
                       bus.sys_enable, bus.busy, bus.done, bus.tile_count);
            end
            reset = 1'b0;
            for (int i = 0; i < 6; i++) begin
              @(negedge clk);
              checks++;
              if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL after_reset_idle got done=%b busy=%b want 0/0",
                         bus.done, bus.busy);
              end
            end
            exp_q.delete();
            return;
          end
        end
        checks++;
        if (bus.tile_m !== W'(t.m) || bus.tile_k !== W'(t.k) ||
            bus.tile_n !== W'(t.n) || bus.m_off !== W'(t.mo) ||
            bus.k_off !== W'(t.ko) || bus.n_off !== W'(t.no) ||
            bus.acc_first !== t.f || bus.acc_last !== t.l) begin
          failures++;
          $display("FAIL tile idx=%0d got %0dx%0dx%0d off=%0d,%0d,%0d f=%b l=%b want %0dx%0dx%0d off=%0d,%0d,%0d f=%b l=%b",
                   idx - 1, bus.tile_m, bus.tile_k, bus.tile_n,
                   bus.m_off, bus.k_off, bus.n_off,
                   bus.acc_first, bus.acc_last,
                   t.m, t.k, t.n, t.mo, t.ko, t.no, t.f, t.l);
        end
        bus.sys_finish = (en_cnt >= lat);
        en_cnt++;
        bus.start = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
        low = 0;
      end else begin
        low++;
        if (cyc > 1) bus.start = 1'b0;
        bus.sys_finish = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (bus.done === 1'b1) begin
        checks++;
        if (bus.busy !== 1'b1 || bus.sys_enable !== 1'b0 ||
            bus.tile_count !== 16'(ntiles) || idx != ntiles ||
            exp_q.size() != 0) begin
          failures++;
          $display("FAIL done_state got busy=%b en=%b cnt=%0d tiles=%0d want 1/0/%0d/%0d",
                   bus.busy, bus.sys_enable, bus.tile_count, idx,
                   ntiles, ntiles);
        end
        if (ntiles > 0) begin
          checks++;
          if (bus.m_off !== '0 || bus.k_off !== '0 ||
              bus.n_off !== W'(last_t.no) ||
              bus.tile_m !== W'(last_t.m) ||
              bus.tile_k !== W'(last_t.k) ||
              bus.tile_n !== W'(last_t.n)) begin
            failures++;
            $display("FAIL done_hold got off=%0d,%0d,%0d tile=%0dx%0dx%0d want off=0,0,%0d tile=%0dx%0dx%0d",
                     bus.m_off, bus.k_off, bus.n_off,
                     bus.tile_m, bus.tile_k, bus.tile_n,
                     last_t.no, last_t.m, last_t.k, last_t.n);
          end
        end
        bus.sys_finish = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
          failures++;
          $display("FAIL idle_after_done got busy=%b done=%b want 0/0",
                   bus.busy, bus.done);
        end
        ended = 1'b1;
      end
      prev_en = bus.sys_enable;
    end
    if (!ended) begin
      checks++;
      failures++;
      $display("FAIL job_timeout got tiles=%0d want done within budget",
               idx);
    end
    bus.sys_finish = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b1;
    bus.dim_m = 8'd5;
    bus.dim_k = 8'd5;
    bus.dim_n = 8'd5;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.sys_enable !== 1'b0 ||
        bus.done !== 1'b0 || bus.tile_count !== 16'd0 ||
        bus.m_off !== '0 || bus.tile_m !== '0 ||
        bus.acc_first !== 1'b0 || bus.ws_os !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got busy=%b en=%b done=%b cnt=%0d want 0",
               bus.busy, bus.sys_enable, bus.done, bus.tile_count);
    end
    bus.start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_start got busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_single_tile();
    run_job(8, 8, 8, 1'b0, 29, 1'b0, 0);
    checks++;
    if (last_seen.m != 8 || last_seen.k != 8 || last_seen.n != 8 ||
        last_seen.mo != 0 || last_seen.f != 1'b1 ||
        last_seen.l != 1'b1) begin
      failures++;
      $display("FAIL single_tile got %0dx%0dx%0d f=%b l=%b want 8x8x8 f=1 l=1",
               last_seen.m, last_seen.k, last_seen.n,
               last_seen.f, last_seen.l);
    end
  endtask

  task automatic test_multi_tile();
    run_job(20, 10, 8, 1'b1, -1, 1'b0, 0);
    checks++;
    if (last_seen.mo != 16 || last_seen.ko != 8 || last_seen.m != 4 ||
        last_seen.k != 2 || last_seen.l != 1'b1 ||
        bus.tile_count !== 16'd4) begin
      failures++;
      $display("FAIL multi_last got off=%0d,%0d %0dx%0d cnt=%0d want 16,8 4x2 cnt=4",
               last_seen.mo, last_seen.ko, last_seen.m, last_seen.k,
               bus.tile_count);
    end
  endtask

  task automatic test_large();
    run_job(255, 255, 17, 1'b0, 0, 1'b0, 0);
    checks++;
    if (last_seen.mo != 240 || last_seen.m != 15 ||
        last_seen.ko != 248 || last_seen.k != 7 ||
        last_seen.no != 16 || last_seen.n != 1 ||
        bus.tile_count !== 16'd1536) begin
      failures++;
      $display("FAIL large_last got off=%0d,%0d,%0d %0dx%0dx%0d cnt=%0d want 240,248,16 15x7x1 cnt=1536",
               last_seen.mo, last_seen.ko, last_seen.no, last_seen.m,
               last_seen.k, last_seen.n, bus.tile_count);
    end
  endtask

  task automatic test_zero_dim();
    run_job(9, 0, 9, 1'b0, -1, 1'b0, 0);
    run_job(0, 3, 3, 1'b1, -1, 1'b0, 0);
  endtask

  task automatic test_ignored_inputs();
    run_job(20, 10, 8, 1'b0, -1, 1'b1, 0);
    run_job(33, 17, 9, 1'b1, -1, 1'b1, 0);
  endtask

  task automatic test_reset_mid_run();
    run_job(20, 10, 8, 1'b1, 4, 1'b0, 2);
    run_job(20, 10, 8, 1'b0, -1, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      run_job($urandom_range(1, 45), $urandom_range(1, 30),
              $urandom_range(1, 30), 1'($urandom_range(0, 1)), -1,
              1'($urandom_range(0, 1)), 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.dim_m = '0;
    bus.dim_k = '0;
    bus.dim_n = '0;
    bus.ws_os_in = 1'b0;
    bus.sys_finish = 1'b0;
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_large();
    test_zero_dim();
    test_ignored_inputs();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
